kr_scan_engine: RTL and testbench

Datapath end of the Knight Rider scanner. It consumes the 1-bit direction from the direction FSM and produces the 4-bit position count that the FSM monitors. It steps the position at a programmable rate and drives the LED bar: the head LED at full brightness, followed by a PWM-dimmed two-LED trail. It sits between the direction FSM and the board LED pins, closing the count/dir loop.

---
 rtl/kr_pkg.sv | 7 +
 rtl/kr_prescaler.sv | 19 +
 rtl/kr_scan_engine.sv | 59 +++++
 tb/tb_kr_scan_engine.sv | 119 +++++++++++
 4 files changed

// File: rtl/kr_pkg.sv
// kr_pkg: shared direction encoding and sizing for the Knight Rider scanner
package kr_pkg;
  localparam logic DIR_LEFT = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam int DEF_N_LEDS = 8;
  localparam int COUNT_W = 4;
endpackage

// File: rtl/kr_prescaler.sv
// kr_prescaler: programmable-rate step tick generator
module kr_prescaler #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] speed,
  output logic       tick
);
  logic [31:0] pre, span, last;
  // a limit shifted down to zero still means one tick per clock
  assign span = 32'(TICK_DIV) >> speed;
  assign last = (span == 32'd0) ? 32'd0 : span - 32'd1;
  assign tick = enable && (pre >= last);
  always_ff @(posedge clk or posedge reset)
    if (reset) pre <= '0;
    else if (enable) pre <= tick ? 32'd0 : pre + 32'd1;
endmodule

// File: rtl/kr_scan_engine.sv
// kr_scan_engine: steps the scanner head position and drives the LED bar with a
// PWM-dimmed two-LED trail
module kr_scan_engine
  import kr_pkg::*;
#(
  parameter int N_LEDS = DEF_N_LEDS,
  parameter int TICK_DIV = 12_500_000,
  parameter int PWM_BITS = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               dir,
  input  logic [1:0]         speed,
  output logic [COUNT_W-1:0] count,
  output logic               step,
  output logic [N_LEDS-1:0]  leds
);
  localparam logic [PWM_BITS-1:0] HALF = PWM_BITS'(1) << (PWM_BITS - 1);
  logic tick, move, v0, v1;
  logic [COUNT_W-1:0] nxt, hist0, hist1;
  logic [PWM_BITS-1:0] pwm;
  logic [N_LEDS-1:0] led_nxt;
  kr_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk(clk), .reset(reset), .enable(enable), .speed(speed), .tick(tick)
  );
  // a tick at an end with dir pointing outward holds the head
  always_comb begin
    move = tick && ((dir == DIR_LEFT) ? (count < COUNT_W'(N_LEDS - 1)) : (count != '0));
    nxt = (dir == DIR_LEFT) ? count + COUNT_W'(1) : count - COUNT_W'(1);
    led_nxt = '0;
    for (int i = 0; i < N_LEDS; i++)
      led_nxt[i] = (count == COUNT_W'(i))
                || (v0 && hist0 == COUNT_W'(i) && pwm < HALF)
                || (v1 && hist1 == COUNT_W'(i) && pwm == '0);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      count <= '0;
      step <= 1'b0;
      leds <= '0;
      pwm <= '0;
      hist0 <= '0;
      hist1 <= '0;
      v0 <= 1'b0;
      v1 <= 1'b0;
    end else begin
      pwm <= pwm + PWM_BITS'(1);
      step <= tick;
      leds <= led_nxt;
      if (move) begin
        count <= nxt;
        hist0 <= count;
        hist1 <= hist0;
        v0 <= 1'b1;
        v1 <= v0;
      end
    end
endmodule

// File: tb/tb_kr_scan_engine.sv
// tb_kr_scan_engine: directed checks of stepping, trail duty, bounce, saturation,
// speed change and async reset; TICK_DIV=8 so speed=1 gives a 4-clock period
module tb_kr_scan_engine;
  import kr_pkg::*;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, dir = DIR_LEFT;
  logic [1:0] speed = 2'd1;
  logic [3:0] count;
  logic step;
  logic [7:0] leds;
  int n_chk = 0, n_fail = 0, k = 0;
  int exp_seq [20] = '{4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2, 3, 4, 5, 6, 7, 6, 5};

  kr_scan_engine #(.N_LEDS(8), .TICK_DIV(8), .PWM_BITS(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .dir(dir), .speed(speed),
    .count(count), .step(step), .leds(leds)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic wait_step(input string tag);
    int t = 0;
    do begin
      cyc();
      t++;
    end while (step !== 1'b1 && t < 16);
    chk({tag, "_step_seen"}, 32'(step), 32'd1);
  endtask

  initial begin
    int p;
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_step", 32'(step), 0);
    chk("rst_leds", 32'(leds), 0);
    reset = 1'b0;
    k = 0;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      chk("step_seq", 32'(step), (c % 4 == 0) ? 1 : 0);
      chk("count_seq", 32'(count), 32'(c / 4));
      if (c == 1) chk("first_leds", 32'(leds), 32'h01);
    end
    enable = 1'b0;
    for (int c = 13; c <= 20; c++) begin
      cyc();
      p = (k - 1) % 4;
      chk("trail_leds", 32'(leds), 32'h08 | ((p < 2) ? 32'h04 : 0) | ((p == 0) ? 32'h02 : 0));
      chk("frozen_step", 32'(step), 0);
    end
    chk("frozen_count", 32'(count), 3);
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wait_step("loop");
      chk("loop_count", 32'(count), 32'(exp_seq[i]));
      chk("loop_range", 32'(count <= 4'd7), 1);
      if (count == 4'd7) dir = DIR_RIGHT;
      else if (count == 4'd0) dir = DIR_LEFT;
    end
    dir = DIR_LEFT;
    wait_step("to6");
    wait_step("to7");
    chk("sat_pre_count", 32'(count), 7);
    chk("sat_pre_hist0", 32'(dut.hist0), 6);
    wait_step("sat");
    chk("sat_count", 32'(count), 7);
    chk("sat_hist0", 32'(dut.hist0), 6);
    speed = 2'd0;
    repeat (3) begin
      cyc();
      chk("slow_nostep", 32'(step), 0);
    end
    speed = 2'd2;
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk("speed_change_step", 32'(step), (c % 2 == 0) ? 1 : 0);
    end
    speed = 2'd3;
    dir = DIR_RIGHT;
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("fast_step", 32'(step), 1);
      chk("fast_count", 32'(count), 32'(6 - c));
    end
    speed = 2'd1;
    dir = DIR_LEFT;
    wait_step("to5");
    chk("pre_reset_count", 32'(count), 5);
    #2;
    reset = 1'b1;
    #1;
    chk("async_count", 32'(count), 0);
    chk("async_leds", 32'(leds), 0);
    chk("async_step", 32'(step), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc();
    chk("rerelease_leds", 32'(leds), 32'h01);
    chk("rerelease_count", 32'(count), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
